// File: rtl/hw_pkg.sv
// hw_pkg: types and widths shared by the hidden-layer sequencer, the
// accumulator and the output layer.
//   hw_seq_state_t   : sequencer FSM state encoding
//   WEIGHT_W, SUM_W  : weight and running-sum widths (two's complement)
//   N_INPUTS_DEFAULT : default fan-in of one neuron
package hw_pkg;

    localparam int WEIGHT_W         = 8;
    localparam int SUM_W            = 32;
    localparam int N_INPUTS_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACC   = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } hw_seq_state_t;

endpackage

// File: rtl/hw_activation.sv
// hw_activation: purely combinational neuron activation.
//   z_i         in  SUM_W  signed sum
//   threshold_i in  SUM_W  signed threshold
//   h_o         out 1      1 iff z_i >= threshold_i (signed)
//   act_o       out SUM_W  ReLU(z_i)
// The caller registers the outputs.
module hw_activation
    import hw_pkg::*;
(
    input  logic signed [SUM_W-1:0] z_i,
    input  logic signed [SUM_W-1:0] threshold_i,
    output logic                    h_o,
    output logic signed [SUM_W-1:0] act_o
);

    assign h_o   = (z_i >= threshold_i);
    assign act_o = (z_i > 0) ? z_i : '0;

endmodule

// File: rtl/hw_sequencer.sv
// hw_sequencer: drives the x*w accumulator through one neuron evaluation.
//   Clk, RST                clock, async active-low reset
//   Start, Abort            begin evaluation (IDLE only) / synchronous abort
//   X_vec, Threshold        operands latched on an accepted Start
//   W_addr, W_data          weight ROM port (data valid one cycle after addr)
//   w, x, ComputeH, Get,    accumulator controls
//   RstSum, Z               accumulator clear / registered running sum
//   H, Act                  registered activation and ReLU result
//   Busy, Done              status; Done is a one-cycle pulse
//
// state | meaning
// IDLE  | waiting for Start
// CLEAR | clear accumulator, present weight address 0
// ACC   | one weight/input pair per cycle, N_INPUTS cycles
// EVAL  | Z holds the full sum; register H and Act
// DONE  | Done pulse, results valid
module hw_sequencer
    import hw_pkg::*;
#(
    parameter  int N_INPUTS = N_INPUTS_DEFAULT,
    localparam int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                       Clk,
    input  logic                       RST,
    input  logic                       Start,
    input  logic                       Abort,
    input  logic [N_INPUTS-1:0]        X_vec,
    input  logic signed [SUM_W-1:0]    Threshold,
    output logic [ADDR_W-1:0]          W_addr,
    input  logic signed [WEIGHT_W-1:0] W_data,
    output logic signed [WEIGHT_W-1:0] w,
    output logic                       x,
    output logic                       ComputeH,
    output logic                       Get,
    output logic                       RstSum,
    input  logic signed [SUM_W-1:0]    Z,
    output logic                       H,
    output logic signed [SUM_W-1:0]    Act,
    output logic                       Busy,
    output logic                       Done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

    hw_seq_state_t           state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [N_INPUTS-1:0]     x_q, x_d;
    logic signed [SUM_W-1:0] thr_q, thr_d;
    logic                    h_q, h_d;
    logic signed [SUM_W-1:0] act_q, act_d;

    logic                    act_h;
    logic signed [SUM_W-1:0] act_relu;

    hw_activation u_activation (
        .z_i         (Z),
        .threshold_i (thr_q),
        .h_o         (act_h),
        .act_o       (act_relu)
    );

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            thr_q   <= '0;
            h_q     <= 1'b0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            thr_q   <= thr_d;
            h_q     <= h_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        x_d      = x_q;
        thr_d    = thr_q;
        h_d      = h_q;
        act_d    = act_q;
        W_addr   = '0;
        w        = '0;
        x        = 1'b0;
        ComputeH = 1'b0;
        Get      = 1'b0;
        RstSum   = 1'b0;
        Done     = 1'b0;

        if (Abort) begin
            // Accumulation is gated off as well: the sum is being cleared anyway.
            RstSum  = 1'b1;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        x_d     = X_vec;
                        thr_d   = Threshold;
                        state_d = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    RstSum  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_ACC;
                end
                ST_ACC: begin
                    w        = W_data;
                    x        = x_q[idx_q];
                    ComputeH = 1'b1;
                    Get      = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // No further prefetch; hold the address in range.
                        W_addr  = LAST_IDX;
                        state_d = ST_EVAL;
                    end else begin
                        W_addr = idx_q + 1'b1;
                        idx_d  = idx_q + 1'b1;
                    end
                end
                ST_EVAL: begin
                    h_d     = act_h;
                    act_d   = act_relu;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    Done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign H    = h_q;
    assign Act  = act_q;
    assign Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hw_sequencer.sv
module tb_hw_sequencer;
    import hw_pkg::*;

    logic Clk;
    logic RST;

    // N = 4 instance
    logic              start4, abort4;
    logic [3:0]        xv4;
    logic signed [31:0] thr4;
    logic [1:0]        wa4;
    logic signed [7:0] wd4, w4;
    logic              x4, ch4, get4, rs4, h4, busy4, done4;
    logic signed [31:0] z4, act4;
    logic [7:0]        rom4 [4];

    // N = 16 instance
    logic              start16, abort16;
    logic [15:0]       xv16;
    logic signed [31:0] thr16;
    logic [3:0]        wa16;
    logic signed [7:0] wd16, w16;
    logic              x16, ch16, get16, rs16, h16, busy16, done16;
    logic signed [31:0] z16, act16;
    logic [7:0]        rom16 [16];

    int checks = 0;
    int failures = 0;

    hw_sequencer #(.N_INPUTS(4)) dut4 (
        .Clk(Clk), .RST(RST), .Start(start4), .Abort(abort4),
        .X_vec(xv4), .Threshold(thr4), .W_addr(wa4), .W_data(wd4),
        .w(w4), .x(x4), .ComputeH(ch4), .Get(get4), .RstSum(rs4),
        .Z(z4), .H(h4), .Act(act4), .Busy(busy4), .Done(done4)
    );

    hw_sequencer #(.N_INPUTS(16)) dut16 (
        .Clk(Clk), .RST(RST), .Start(start16), .Abort(abort16),
        .X_vec(xv16), .Threshold(thr16), .W_addr(wa16), .W_data(wd16),
        .w(w16), .x(x16), .ComputeH(ch16), .Get(get16), .RstSum(rs16),
        .Z(z16), .H(h16), .Act(act16), .Busy(busy16), .Done(done16)
    );

    // Behavioural 1-cycle ROMs and accumulators (accumulator reset tied off).
    always @(posedge Clk) begin
        wd4  <= rom4[wa4];
        wd16 <= rom16[wa16];
        if (rs4) z4 <= '0;
        else if (ch4 && get4) z4 <= z4 + (x4 ? {{24{w4[7]}}, w4} : 32'sd0);
        if (rs16) z16 <= '0;
        else if (ch16 && get16) z16 <= z16 + (x16 ? {{24{w16[7]}}, w16} : 32'sd0);
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until Done of the chosen instance, counting the Start edge as 1.
    task automatic wait_done(input bit big, output int n);
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if ((big ? done16 : done4) === 1'b1) break;
        end
    endtask

    initial begin
        int n, g, nd;
        RST = 1'b0;
        start4 = 0; abort4 = 0; xv4 = '0; thr4 = '0;
        start16 = 0; abort16 = 0; xv16 = '0; thr16 = '0;
        rom4[0] = 8'sd3; rom4[1] = -8'sd2; rom4[2] = 8'sd5; rom4[3] = 8'sd1;
        for (int i = 0; i < 16; i++) rom16[i] = 8'h80;
        repeat (3) tick();

        // Reset state
        chk1("rst_busy", busy4, 1'b0);
        chk1("rst_done", done4, 1'b0);
        chk1("rst_h", h4, 1'b0);
        chk32("rst_act", act4, 0);
        chk32("rst_waddr", 32'(wa4), 0);
        chk1("rst_rstsum", rs4, 1'b0);
        chk1("rst_computeh", ch4, 1'b0);
        chk1("rst_busy16", busy16, 1'b0);
        RST = 1'b1;
        tick();

        // All ones, N=4: cycle-by-cycle
        xv4 = 4'b1111; thr4 = 7; start4 = 1;
        tick();
        start4 = 0;
        chk1("clear_rstsum", rs4, 1'b1);
        chk32("clear_waddr", 32'(wa4), 0);
        chk1("clear_busy", busy4, 1'b1);
        tick();
        chk1("acc0_computeh", ch4, 1'b1);
        chk1("acc0_get", get4, 1'b1);
        chk32("acc0_w", 32'(w4), 3);
        chk1("acc0_x", x4, 1'b1);
        chk32("acc0_waddr", 32'(wa4), 1);
        chk1("acc0_rstsum", rs4, 1'b0);
        repeat (3) tick();
        chk32("acc3_waddr_hold", 32'(wa4), 3);
        chk32("acc3_w", 32'(w4), 1);
        tick();
        chk1("eval_computeh", ch4, 1'b0);
        chk32("eval_z", z4, 7);
        chk1("eval_done", done4, 1'b0);
        tick();
        chk1("t1_done", done4, 1'b1);
        chk1("t1_h", h4, 1'b1);
        chk32("t1_act", act4, 7);
        tick();
        chk1("t1_done_pulse", done4, 1'b0);
        chk1("t1_idle", busy4, 1'b0);

        // Abort in the 3rd ACC cycle
        xv4 = 4'b0101; thr4 = 100; start4 = 1;
        tick();
        start4 = 0;
        repeat (3) tick();
        abort4 = 1;
        #1;
        chk1("abort_rstsum", rs4, 1'b1);
        tick();
        abort4 = 0;
        chk1("abort_idle", busy4, 1'b0);
        chk32("abort_z_cleared", z4, 0);
        chk1("abort_h_kept", h4, 1'b1);
        chk32("abort_act_kept", act4, 7);
        nd = 0;
        repeat (10) begin tick(); if (done4) nd++; end
        chk32("abort_no_done", nd, 0);
        start4 = 1;
        wait_done(0, n);
        start4 = 0;
        chk32("post_abort_latency", n, 7);
        chk32("post_abort_z", z4, 8);
        chk1("post_abort_h", h4, 1'b0);
        chk32("post_abort_act", act4, 8);
        tick();

        // Start with Abort in IDLE: abort wins
        start4 = 1; abort4 = 1; xv4 = 4'b1111;
        tick();
        start4 = 0; abort4 = 0;
        chk1("start_abort_idle", busy4, 1'b0);
        tick();
        chk1("start_abort_idle2", busy4, 1'b0);

        // Sparse inputs, negative sum
        xv4 = 4'b0010; thr4 = 0; start4 = 1;
        wait_done(0, n);
        start4 = 0;
        chk32("sparse_latency", n, 7);
        chk32("sparse_z", z4, -2);
        chk1("sparse_h", h4, 1'b0);
        chk32("sparse_act", act4, 0);
        tick();

        // Abort during DONE suppresses the pulse
        xv4 = 4'b1111; thr4 = 7; start4 = 1;
        tick();
        start4 = 0;
        repeat (6) tick();
        abort4 = 1;
        #1;
        chk1("abort_done_suppressed", done4, 1'b0);
        chk1("abort_done_rstsum", rs4, 1'b1);
        tick();
        abort4 = 0;
        chk1("abort_done_idle", busy4, 1'b0);

        // Back-to-back runs with Start held high
        xv4 = 4'b1111; thr4 = 7; start4 = 1;
        wait_done(0, n);
        chk32("b2b_first_latency", n, 7);
        chk1("b2b_first_h", h4, 1'b1);
        chk32("b2b_first_act", act4, 7);
        xv4 = 4'b1000; thr4 = 2;
        g = 0;
        do begin
            tick();
            g++;
            if (g == 2) start4 = 0;
        end while (!done4 && g < 40);
        chk32("b2b_period", g, 8);
        chk32("b2b_second_z", z4, 1);
        chk1("b2b_second_h", h4, 1'b0);
        chk32("b2b_second_act", act4, 1);
        start4 = 0;
        tick();

        // Extreme weights, N=16
        xv16 = 16'hFFFF; thr16 = -2048; start16 = 1;
        wait_done(1, n);
        start16 = 0;
        chk32("neg_latency", n, 19);
        chk32("neg_z", z16, -2048);
        chk1("neg_h_equal", h16, 1'b1);
        chk32("neg_act", act16, 0);
        tick();
        for (int i = 0; i < 16; i++) rom16[i] = 8'h7F;
        thr16 = 2033; start16 = 1;
        wait_done(1, n);
        start16 = 0;
        chk32("pos_z", z16, 2032);
        chk1("pos_h_below", h16, 1'b0);
        chk32("pos_act", act16, 2032);
        tick();

        // Async reset during ACC
        start16 = 1;
        tick();
        start16 = 0;
        repeat (3) tick();
        #2 RST = 1'b0;
        #1;
        chk1("arst_busy", busy16, 1'b0);
        chk1("arst_computeh", ch16, 1'b0);
        chk32("arst_act", act16, 0);
        chk32("arst_waddr", 32'(wa16), 0);
        chk1("arst_done", done16, 1'b0);
        tick();
        RST = 1'b1;
        tick();

        // Start pulsed while busy is ignored; exactly one Done
        thr16 = 2032; start16 = 1;
        tick();
        start16 = 0;
        repeat (4) tick();
        start16 = 1;
        tick();
        start16 = 0;
        nd = 0;
        repeat (30) begin tick(); if (done16) nd++; end
        chk32("busy_start_one_done", nd, 1);
        chk32("busy_start_z", z16, 2032);
        chk1("busy_start_h", h16, 1'b1);
        chk32("busy_start_act", act16, 2032);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
